// File: rtl/kw_decode_pipe_pkg.sv
// Shared defaults for the keyword index-decode pipeline.
package kw_decode_pipe_pkg;

    localparam int KW_O_WIDTH_DEF   = 8;
    localparam int KW_CNT_WIDTH_DEF = 8;
    localparam int KW_THERMO_DEF    = 0;

endpackage

// File: rtl/kw_decode_pipe_decode.sv
// KW_decode: combinational binary index to one-hot decoder, zero latency, no flow control.
// Indices with no matching output bit decode to all zeros.
module KW_decode #(
    parameter int I_WIDTH = 3,
    parameter int O_WIDTH = 8
) (
    input  logic [I_WIDTH-1:0] idx_i,
    output logic [O_WIDTH-1:0] dec_o
);

    always_comb begin
        dec_o = '0;
        for (int k = 0; k < O_WIDTH; k++) begin
            dec_o[k] = (idx_i == I_WIDTH'(k));
        end
    end

endmodule

// File: rtl/kw_decode_pipe.sv
// Index decoder (one-hot or thermometer) behind a 2-entry main+skid buffer; 1-cycle latency.
// Backpressure: o_r low fills the skid entry, then i_r drops; i_r comes only from registered state.
module kw_decode_pipe
    import kw_decode_pipe_pkg::*;
#(
    parameter int O_WIDTH   = KW_O_WIDTH_DEF,
    parameter int I_WIDTH   = $clog2(O_WIDTH),
    parameter int THERMO    = KW_THERMO_DEF,
    parameter int CNT_WIDTH = KW_CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_v,
    output logic                 i_r,
    input  logic [I_WIDTH-1:0]   i,
    output logic                 o_v,
    input  logic                 o_r,
    output logic [O_WIDTH-1:0]   o,
    output logic                 o_err,
    input  logic                 err_clr,
    output logic [CNT_WIDTH-1:0] err_cnt
);

    logic [O_WIDTH-1:0]   onehot;
    logic [O_WIDTH-1:0]   therm;
    logic [O_WIDTH-1:0]   dec_dat;
    logic                 dec_err;
    logic                 in_fire;
    logic                 out_fire;

    logic                 main_vld_q, main_vld_d;
    logic [O_WIDTH-1:0]   main_dat_q, main_dat_d;
    logic                 main_err_q, main_err_d;
    logic                 skid_vld_q, skid_vld_d;
    logic [O_WIDTH-1:0]   skid_dat_q, skid_dat_d;
    logic                 skid_err_q, skid_err_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    KW_decode #(
        .I_WIDTH (I_WIDTH),
        .O_WIDTH (O_WIDTH)
    ) u_dec (
        .idx_i (i),
        .dec_o (onehot)
    );

    // Thermometer bit k is set when the index is k or above, i.e. any one-hot bit at or above k.
    for (genvar k = 0; k < O_WIDTH; k++) begin : g_therm
        assign therm[k] = |onehot[O_WIDTH-1:k];
    end

    // Out-of-range indices hit no one-hot bit, so both encodings come out all zeros.
    assign dec_err = ~|onehot;
    assign dec_dat = (THERMO != 0) ? therm : onehot;

    assign in_fire  = i_v & i_r;
    assign out_fire = main_vld_q & o_r;

    always_comb begin
        main_vld_d = main_vld_q;
        main_dat_d = main_dat_q;
        main_err_d = main_err_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        skid_err_d = skid_err_q;
        cnt_d      = cnt_q;

        if (!main_vld_q || out_fire) begin
            if (skid_vld_q) begin
                main_vld_d = 1'b1;
                main_dat_d = skid_dat_q;
                main_err_d = skid_err_q;
                skid_vld_d = 1'b0;
                skid_dat_d = '0;
                skid_err_d = 1'b0;
            end else begin
                main_vld_d = in_fire;
                main_dat_d = in_fire ? dec_dat : '0;
                main_err_d = in_fire & dec_err;
            end
        end else if (in_fire) begin
            skid_vld_d = 1'b1;
            skid_dat_d = dec_dat;
            skid_err_d = dec_err;
        end

        if (err_clr) begin
            cnt_d = '0;
        end else if (in_fire && dec_err && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld_q <= 1'b0;
            main_dat_q <= '0;
            main_err_q <= 1'b0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
            skid_err_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            main_dat_q <= main_dat_d;
            main_err_q <= main_err_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
            skid_err_q <= skid_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign i_r     = ~skid_vld_q;
    assign o_v     = main_vld_q;
    assign o       = main_dat_q;
    assign o_err   = main_err_q;
    assign err_cnt = cnt_q;

endmodule

// File: doc/kw_decode_pipe.md
KW_DECODE_PIPE -- requirements
Module: kw_decode_pipe

Interface
REQ-001 SHALL have parameter O_WIDTH, default 8, number of decoded output bits (>=2).
REQ-002 SHALL have parameter I_WIDTH, default $clog2(O_WIDTH), index width.
REQ-003 SHALL have parameter THERMO, default 0, 0 = one-hot output, 1 = thermometer output.
REQ-004 SHALL have parameter CNT_WIDTH, default 8, error-counter width.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_v  input  1  input index valid.
REQ-008 SHALL have port i_r  output  1  input ready.
REQ-009 SHALL have port i  input  I_WIDTH  index to decode.
REQ-010 SHALL have port o_v  output  1  output valid.
REQ-011 SHALL have port o_r  input  1  downstream ready.
REQ-012 SHALL have port o  output  O_WIDTH  decoded vector.
REQ-013 SHALL have port o_err  output  1  current output came from an out-of-range index.
REQ-014 SHALL have port err_clr  input  1  synchronous clear of the error counter.
REQ-015 SHALL have port err_cnt  output  CNT_WIDTH  saturating count of out-of-range indices accepted.

Function
REQ-016 SHALL transfer input when i_v && i_r, and output when o_v && o_r, on rising clk.
REQ-017 SHALL decode one-hot when THERMO=0: o[k]=1 only for k==i.
REQ-018 SHALL decode thermometer when THERMO=1: o[k]=1 for all k<=i.
REQ-019 SHALL treat i>=O_WIDTH (possible when 2**I_WIDTH>O_WIDTH) as out-of-range: o all zeros, o_err=1.
REQ-020 SHALL drive o all zeros and o_err=0 whenever o_v=0.
REQ-021 SHALL have latency of exactly 1 cycle: an index accepted in cycle N appears on o with o_v=1 in cycle N+1 if the output stage was empty or drained in cycle N.
REQ-022 SHALL buffer with a main register plus one skid register (2 entries total), preserving order.
REQ-023 SHALL drive i_r from registered state only (skid entry empty), with no combinational path from o_r to i_r.
REQ-024 SHALL hold o, o_err stable while o_v=1 and o_r=0.
REQ-025 SHALL, when the skid entry is occupied and an output transfer occurs, move the skid entry to the main register in the same edge.
REQ-026 SHALL sustain one transfer per cycle with o_r held high.
REQ-027 SHALL increment err_cnt by 1 on each accepted out-of-range index, saturating at 2**CNT_WIDTH-1.
REQ-028 SHALL give err_clr priority over increment: on err_clr, err_cnt becomes 0 next cycle even if an out-of-range index is accepted that cycle.
REQ-029 SHALL ignore i when i_v=0 and never count unaccepted indices.

Reset
REQ-030 SHALL, on rst_n low, asynchronously clear both buffer entries and err_cnt: o_v=0, o=0, o_err=0, err_cnt=0, i_r=1.
REQ-031 SHALL discard in-flight entries on mid-operation reset; first acceptance possible on the first rising edge with rst_n high.

Structure
REQ-032 SHALL take no new package typedefs; the combinational decode SHALL reuse existing KW_decode as one sub-module instance, with thermometer and range logic local.
REQ-033 SHALL place the 2-entry skid buffer in the module body, with no separate FIFO block.

Verification
REQ-034 SHALL check: O_WIDTH=8, THERMO=0, o_r=1, indices 0..7 back-to-back -> o=0x01,0x02,...,0x80 one cycle later, o_v continuous.
REQ-035 SHALL check: THERMO=1, i=3 -> o=0x0F; i=0 -> o=0x01; i=7 -> o=0xFF.
REQ-036 SHALL check: O_WIDTH=6, i=6 and i=7 accepted -> o=0, o_err=1 each, err_cnt=2; then err_clr with a simultaneous i=7 -> err_cnt=0.
REQ-037 SHALL check: o_r=0 while driving i=1,2,3 -> two accepted, i_r=0 after the second, o=0x02 held; o_r=1 -> 0x02,0x04, then 0x08 accepted, order kept.
REQ-038 SHALL check: CNT_WIDTH=2, five out-of-range indices -> err_cnt saturates at 3.
REQ-039 SHALL check: rst_n pulsed low with both entries full -> o_v=0, o=0, err_cnt=0, i_r=1 immediately, without a clock edge.
